// File: rtl/switch_bounce_gen.sv
// switch_bounce_gen -- bouncy push-button emulator.
//
// Turns a clean requested switch level into a contact signal that chatters
// pseudo-randomly for a fixed window before settling on the requested level.
//
// Ports:
//   i_Clk      system clock
//   i_Rst_L    asynchronous active-low reset
//   i_Enable   1 = emulate bounce, 0 = bypass (o_Switch follows i_Press)
//   i_Press    clean requested switch level, synchronous to i_Clk
//   o_Switch   emulated contact output (registered)
//   o_Bouncing high while the chatter window is open
//   o_Settled  one-cycle pulse when a chatter window ends
module switch_bounce_gen #(
  parameter int unsigned BOUNCE_CYCLES = 250000,
  parameter int unsigned MIN_HOLD      = 64,
  parameter int unsigned HOLD_BITS     = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic        IDLE_LEVEL    = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Enable,
  input  logic i_Press,
  output logic o_Switch,
  output logic o_Bouncing,
  output logic o_Settled
);

  localparam int unsigned CNT_W    = $clog2(BOUNCE_CYCLES);
  localparam int unsigned HOLD_MAX = MIN_HOLD + (1 << HOLD_BITS) - 1;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0]       SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [CNT_W-1:0]  WIN_LOAD  = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_BASE = HOLD_W'(MIN_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_BOUNCE
  } state_t;

  state_t            state, state_n;
  logic              level, level_n;
  logic              target, target_n;
  logic [CNT_W-1:0]  bounce_cnt, bounce_cnt_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic [15:0]       lfsr, lfsr_n;
  logic              switch_n, bouncing_n, settled_n;

  logic              restart;
  logic [HOLD_W-1:0] hold_load;

  // Galois LFSR, taps 0xB400; free-running in every state.
  assign lfsr_n    = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};
  assign hold_load = HOLD_BASE + HOLD_W'(lfsr[HOLD_BITS-1:0]);
  assign restart   = (i_Press != target);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= ST_IDLE;
      level      <= IDLE_LEVEL;
      target     <= IDLE_LEVEL;
      bounce_cnt <= '0;
      hold_cnt   <= '0;
      lfsr       <= SEED;
      o_Switch   <= IDLE_LEVEL;
      o_Bouncing <= 1'b0;
      o_Settled  <= 1'b0;
    end else begin
      state      <= state_n;
      level      <= level_n;
      target     <= target_n;
      bounce_cnt <= bounce_cnt_n;
      hold_cnt   <= hold_cnt_n;
      lfsr       <= lfsr_n;
      o_Switch   <= switch_n;
      o_Bouncing <= bouncing_n;
      o_Settled  <= settled_n;
    end
  end

  always_comb begin
    state_n      = state;
    level_n      = level;
    target_n     = target;
    bounce_cnt_n = bounce_cnt;
    hold_cnt_n   = hold_cnt;
    switch_n     = o_Switch;
    bouncing_n   = o_Bouncing;
    settled_n    = 1'b0;

    if (!i_Enable) begin
      // Bypass: follow the request directly; any open window is dropped silently.
      state_n    = ST_IDLE;
      switch_n   = i_Press;
      level_n    = i_Press;
      bouncing_n = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          switch_n = level;
          if (i_Press != level) begin
            state_n      = ST_BOUNCE;
            target_n     = i_Press;
            bounce_cnt_n = WIN_LOAD;
            hold_cnt_n   = hold_load;
            switch_n     = ~level;
            bouncing_n   = 1'b1;
          end
        end

        ST_BOUNCE: begin
          // A request change on the final cycle restarts the window rather
          // than settling; settling also overrides a coincident hold expiry.
          if (!restart && bounce_cnt == '0) begin
            state_n    = ST_IDLE;
            switch_n   = target;
            level_n    = target;
            bouncing_n = 1'b0;
            settled_n  = 1'b1;
          end else begin
            if (restart) begin
              target_n     = i_Press;
              bounce_cnt_n = WIN_LOAD;
            end else begin
              bounce_cnt_n = bounce_cnt - 1'b1;
            end
            if (hold_cnt == HOLD_ONE) begin
              switch_n   = ~o_Switch;
              hold_cnt_n = hold_load;
            end else begin
              hold_cnt_n = hold_cnt - 1'b1;
            end
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_bounce_gen.sv
// tb_switch_bounce_gen -- directed plus randomized checks of switch_bounce_gen
// against a scheduled-event reference model (absolute cycle deadlines).
module tb_switch_bounce_gen;

  localparam int BC   = 100;
  localparam int MH   = 4;
  localparam int HB   = 3;
  localparam int HMAX = MH + (1 << HB) - 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk;
  logic rst_n;
  logic en;
  logic press;
  logic sw, bouncing, settled;

  int checks = 0;
  int errors = 0;

  switch_bounce_gen #(
    .BOUNCE_CYCLES(BC),
    .MIN_HOLD     (MH),
    .HOLD_BITS    (HB),
    .LFSR_SEED    (SEED),
    .IDLE_LEVEL   (1'b0)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Enable  (en),
    .i_Press   (press),
    .o_Switch  (sw),
    .o_Bouncing(bouncing),
    .o_Settled (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: window end and next chatter edge kept as absolute cycle numbers.
  int          cyc = 0;
  logic [15:0] m_lfsr;
  logic        m_sw, m_bouncing, m_settled, m_level, m_target;
  int          m_end, m_next;

  // Observation statistics.
  int   win_len, pulses, n_edges;
  int   edge_q[$];
  logic prev_sw, prev_b;
  int   po_gap[4];

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  task automatic model_reset();
    m_lfsr     = SEED;
    m_sw       = 1'b0;
    m_bouncing = 1'b0;
    m_settled  = 1'b0;
    m_level    = 1'b0;
    m_target   = 1'b0;
    m_end      = 0;
    m_next     = 0;
  endtask

  task automatic model_edge();
    logic [15:0] used;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    used      = m_lfsr;
    m_lfsr    = lfsr_adv(m_lfsr);
    m_settled = 1'b0;
    if (!en) begin
      m_sw       = press;
      m_level    = press;
      m_bouncing = 1'b0;
    end else if (!m_bouncing) begin
      if (press != m_level) begin
        m_bouncing = 1'b1;
        m_target   = press;
        m_end      = cyc + BC;
        m_sw       = ~m_sw;
        m_next     = cyc + MH + int'(used[HB-1:0]);
      end
    end else if (press == m_target && cyc == m_end) begin
      m_bouncing = 1'b0;
      m_sw       = m_target;
      m_level    = m_target;
      m_settled  = 1'b1;
    end else begin
      if (press != m_target) begin
        m_target = press;
        m_end    = cyc + BC;
      end
      if (cyc == m_next) begin
        m_sw   = ~m_sw;
        m_next = cyc + MH + int'(used[HB-1:0]);
      end
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_stats();
    win_len = 0;
    pulses  = 0;
    n_edges = 0;
    edge_q.delete();
  endtask

  task automatic tick();
    int gap;
    @(posedge clk);
    model_edge();
    #1;
    check1("switch", sw, m_sw);
    check1("bouncing", bouncing, m_bouncing);
    check1("settled", settled, m_settled);
    if (bouncing) win_len++;
    if (settled) pulses++;
    if (bouncing && sw !== prev_sw) begin
      if (prev_b && edge_q.size() > 0) begin
        gap = cyc - edge_q[$];
        checks++;
        assert ((gap >= MH && gap <= HMAX) === 1'b1)
        else begin
          errors++;
          $error("FAIL hold_gap cycle=%0d observed=%0d expected=%0d..%0d", cyc, gap, MH, HMAX);
        end
      end
      n_edges++;
      edge_q.push_back(cyc);
    end
    prev_sw = sw;
    prev_b  = bouncing;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic held;
    rst_n   = 1'b0;
    en      = 1'b1;
    press   = 1'b0;
    prev_sw = 1'b0;
    prev_b  = 1'b0;
    model_reset();
    clear_stats();

    // Reset held with the request toggling: outputs stay at idle.
    for (int i = 0; i < 6; i++) begin
      press = ~press;
      tick();
    end
    press = 1'b0;
    rst_n = 1'b1;
    ticks(3);

    // Press: 100-cycle window, settle high, one pulse.
    press = 1'b1;
    clear_stats();
    ticks(BC + 1);
    checkn("press_window", win_len, BC);
    checkn("press_pulses", pulses, 1);
    check1("press_final", sw, 1'b1);
    for (int i = 0; i < 4; i++) po_gap[i] = edge_q[i+1] - edge_q[i];
    clear_stats();
    ticks(20);
    checkn("press_quiet_edges", n_edges, 0);
    checkn("press_quiet_pulses", pulses, 0);

    // Release: mirror of press.
    press = 1'b0;
    clear_stats();
    ticks(BC + 1);
    checkn("release_window", win_len, BC);
    checkn("release_pulses", pulses, 1);
    check1("release_final", sw, 1'b0);
    checkn("release_min_edges", int'(n_edges >= 8), 1);
    ticks(10);

    // Mid-window reversal at window clock 50: window stretches to 150.
    press = 1'b1;
    clear_stats();
    ticks(50);
    press = 1'b0;
    ticks(BC + 1);
    checkn("reversal_window", win_len, 150);
    checkn("reversal_pulses", pulses, 1);
    check1("reversal_final", sw, 1'b0);
    ticks(5);

    // Randomized request / enable activity against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) press = ~press;
      if ($urandom_range(0, 149) == 0) en = ~en;
      tick();
    end
    en = 1'b1;
    ticks(2 * BC);
    check1("random_settled_idle", bouncing, 1'b0);

    // Bypass: output is the request delayed one clock.
    en = 1'b0;
    clear_stats();
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) press = ~press;
      held = press;
      tick();
      check1("bypass_follow", sw, held);
    end
    checkn("bypass_win", win_len, 0);
    checkn("bypass_pulses", pulses, 0);

    // Re-enable: no chatter until the request changes.
    en = 1'b1;
    clear_stats();
    ticks(5);
    checkn("reenable_quiet", win_len, 0);

    // Enable dropped mid-window: abandoned with no pulse.
    press = ~press;
    ticks(30);
    check1("drop_inwindow", bouncing, 1'b1);
    en = 1'b0;
    clear_stats();
    ticks(20);
    checkn("drop_pulses", pulses, 0);
    checkn("drop_win", win_len, 0);
    check1("drop_follow", sw, press);

    // Async reset at window clock 40.
    press = 1'b0;
    ticks(2);
    en = 1'b1;
    ticks(2);
    press = 1'b1;
    ticks(40);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check1("areset_switch", sw, 1'b0);
    check1("areset_bouncing", bouncing, 1'b0);
    check1("areset_settled", settled, 1'b0);
    prev_sw = sw;
    prev_b  = 1'b0;
    press   = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    ticks(3);

    // Same timing after reset as at power-on: identical chatter spacing.
    press = 1'b1;
    clear_stats();
    ticks(BC + 1);
    checkn("post_reset_window", win_len, BC);
    for (int i = 0; i < 4; i++) checkn("lfsr_repeat_gap", edge_q[i+1] - edge_q[i], po_gap[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
